// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and parity-mode constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    function automatic logic par_en(logic [1:0] m);
        return m == PAR_EVEN || m == PAR_ODD;
    endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: push/config/status bundle between the host logic and the UART transmitter
interface uart_tx_fifo_if #(parameter int NB_DATA = 8);
    logic               i_wr;
    logic [NB_DATA-1:0] i_data;
    logic [1:0]         i_parity_mode;
    logic               i_stop2;
    logic               o_ready;
    logic               o_overflow;
    logic               o_busy;
    logic               o_done_tx;
    logic               o_tx;
    modport master (output i_wr, i_data, i_parity_mode, i_stop2,
                    input  o_ready, o_overflow, o_busy, o_done_tx, o_tx);
    modport slave  (input  i_wr, i_data, i_parity_mode, i_stop2,
                    output o_ready, o_overflow, o_busy, o_done_tx, o_tx);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth, no write-through bypass
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic push, pop;
    assign push    = i_push && !o_full;
    assign pop     = i_pop && !o_empty;
    assign o_full  = cnt == CW'(DEPTH);
    assign o_empty = cnt == '0;
    assign o_data  = mem[rp];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (push) mem[wp] <= i_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with runtime parity and 1/2 stop bits
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int OVS     = 16,
    parameter int FIFO_AW = 2
) (
    input logic          i_clk,
    input logic          i_rst_n,
    input logic          i_tick,
    uart_tx_fifo_if.slave bus
);
    localparam int TW = $clog2(2 * OVS);
    localparam int BW = $clog2(NB_DATA);
    state_t state, nxt;
    logic [TW-1:0] tick_cnt, last;
    logic [BW-1:0] bit_cnt;
    logic [NB_DATA-1:0] shift, fifo_q;
    logic par_q, par_en_q, stop2_q, pop, full, empty, bit_end, tx_d;
    sync_fifo #(.DEPTH(2 ** FIFO_AW), .WIDTH(NB_DATA)) u_fifo (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_push (bus.i_wr),
        .i_pop  (pop),
        .i_data (bus.i_data),
        .o_data (fifo_q),
        .o_full (full),
        .o_empty(empty)
    );
    // the stop bit stretches to two bit periods when stop2 was latched
    assign last           = (state == STOP && stop2_q) ? TW'(2 * OVS - 1) : TW'(OVS - 1);
    assign bit_end        = i_tick && tick_cnt == last;
    assign bus.o_ready    = !full;
    assign bus.o_overflow = bus.i_wr && full;
    assign bus.o_busy     = state != IDLE || !empty;
    assign bus.o_done_tx  = state == STOP && bit_end;
    always_comb begin
        nxt  = state;
        pop  = 1'b0;
        tx_d = 1'b1;
        case (state)
            IDLE: begin
                pop = !empty;
                nxt = empty ? IDLE : START;
            end
            START: begin
                tx_d = 1'b0;
                nxt  = bit_end ? DATA : START;
            end
            DATA: begin
                tx_d = shift[0];
                if (bit_end && bit_cnt == BW'(NB_DATA - 1)) nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                tx_d = par_q;
                if (bit_end) nxt = STOP;
            end
            STOP: if (bit_end) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            bus.o_tx <= 1'b1;
        end else begin
            state    <= nxt;
            bus.o_tx <= tx_d;
            if (pop) begin
                shift    <= fifo_q;
                par_q    <= (bus.i_parity_mode == PAR_ODD) ? ~^fifo_q : ^fifo_q;
                par_en_q <= par_en(bus.i_parity_mode);
                stop2_q  <= bus.i_stop2;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE && i_tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
                if (bit_end && state == DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: frame-level model of the serial line checked every cycle, plus directed pins
module tb_uart_tx_fifo;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.NB_DATA(8)) b0 ();
    uart_tx_fifo_if #(.NB_DATA(7)) b1 ();
    uart_tx_fifo #(.NB_DATA(8), .OVS(16), .FIFO_AW(2)) d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .bus(b0.slave));
    uart_tx_fifo #(.NB_DATA(7), .OVS(8), .FIFO_AW(2)) d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .bus(b1.slave));

    int n_chk = 0, n_pass = 0, tph = 0;
    int nb[2] = '{8, 7};
    int ovs[2] = '{16, 8};
    int q0[$], q1[$];
    int fb[2][16], fd[2][16];
    int flen[2] = '{0, 0}, idx[2] = '{0, 0}, cnt[2] = '{0, 0};
    int idle_t[2] = '{0, 0}, dcnt[2] = '{0, 0}, done_at[2] = '{0, 0};
    bit in_fr[2] = '{0, 0}, b2b[2] = '{0, 0};
    logic [15:0] cap[2];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int qs(int k);
        return k ? q1.size() : q0.size();
    endfunction

    // expected frame straight from the framing rules: start, LSB-first data, parity, stop
    task automatic build(int k, int w, int mode, bit s2);
        int ones = 0, n = 0;
        fb[k][n] = 0; fd[k][n] = ovs[k]; n++;
        for (int i = 0; i < nb[k]; i++) begin
            fb[k][n] = (w >> i) & 1; ones += fb[k][n]; fd[k][n] = ovs[k]; n++;
        end
        if (mode == 1 || mode == 2) begin
            fb[k][n] = (mode == 1) ? ones % 2 : 1 - ones % 2; fd[k][n] = ovs[k]; n++;
        end
        fb[k][n] = 1; fd[k][n] = s2 ? 2 * ovs[k] : ovs[k]; n++;
        flen[k] = n;
    endtask

    // tp: tick seen at the edge just passed; it belongs to the bit now on the line
    task automatic monitor(bit tp);
        for (int k = 0; k < 2; k++) begin
            logic tx, dn;
            int w;
            tx = k ? b1.o_tx : b0.o_tx;
            dn = k ? b1.o_done_tx : b0.o_done_tx;
            if (dn) dcnt[k]++;
            if (!rst_n) begin
                in_fr[k] = 0;
                if (k == 1) q1.delete(); else q0.delete();
                chk("tx_in_reset", tx, 1);
                chk("done_in_reset", dn, 0);
                continue;
            end
            if (!in_fr[k] && tx == 1'b0) begin
                chk("word_queued_at_start", qs(k) > 0, 1);
                if (qs(k) > 0) begin
                    w = k ? q1.pop_front() : q0.pop_front();
                    if (k == 1) build(k, w, int'(b1.i_parity_mode), b1.i_stop2);
                    else build(k, w, int'(b0.i_parity_mode), b0.i_stop2);
                    if (b2b[k]) chk("idle_ticks_between_frames", idle_t[k], 0);
                    in_fr[k] = 1; idx[k] = 0; cnt[k] = 0; cap[k] = '0;
                end
            end
            if (!in_fr[k]) begin
                chk("idle_line", tx, 1);
                chk("done_when_idle", dn, 0);
                idle_t[k] += int'(tp);
                continue;
            end
            chk("line_bit", tx, fb[k][idx[k]]);
            if (tp) begin
                cnt[k]++;
                if (cnt[k] == 1) cap[k][idx[k]] = tx;
                if (cnt[k] == fd[k][idx[k]]) begin idx[k]++; cnt[k] = 0; end
            end
            if (idx[k] == flen[k]) begin
                in_fr[k] = 0; idle_t[k] = 0; b2b[k] = qs(k) > 0;
            end
            chk("done_pulse", dn, int'(in_fr[k] && idx[k] == flen[k] - 1 &&
                cnt[k] == fd[k][idx[k]] - 1 && tick));
            if (dn) done_at[k] = cnt[k] + 1;
        end
    endtask

    task automatic step(int n = 1);
        bit tp;
        repeat (n) begin
            @(negedge clk);
            tp = tick;
            tph++;
            tick = (tph % 4 == 0);
            #1;
            monitor(tp);
        end
    endtask

    task automatic push(int k, int w, bit acc);
        if (k == 0) begin b0.i_wr = 1'b1; b0.i_data = w[7:0]; end
        else begin b1.i_wr = 1'b1; b1.i_data = w[6:0]; end
        #1;
        chk("ready_before_push", k ? b1.o_ready : b0.o_ready, acc);
        chk("overflow_on_push", k ? b1.o_overflow : b0.o_overflow, !acc);
        if (acc) begin if (k == 1) q1.push_back(w); else q0.push_back(w); end
        step(1);
        b0.i_wr = 1'b0;
        b1.i_wr = 1'b0;
    endtask

    task automatic wait_idle(int k, int budget);
        int c = 0;
        while (c < budget && (in_fr[k] || qs(k) > 0 || (k ? b1.o_busy : b0.o_busy))) begin
            step(1); c++;
        end
        chk("drain_within_budget", c < budget, 1);
        step(4);
    endtask

    task automatic wait_bit(int k, int i, int c, int budget);
        int n = 0;
        while (n < budget && !(in_fr[k] && idx[k] == i && cnt[k] == c)) begin
            step(1); n++;
        end
        chk("reach_bit_within_budget", n < budget, 1);
    endtask

    initial begin
        int d;
        b0.i_wr = 1'b0; b0.i_data = '0; b0.i_parity_mode = PAR_NONE; b0.i_stop2 = 1'b0;
        b1.i_wr = 1'b0; b1.i_data = '0; b1.i_parity_mode = PAR_NONE; b1.i_stop2 = 1'b0;
        step(3);
        chk("reset_tx", b0.o_tx, 1);
        chk("reset_ready", b0.o_ready, 1);
        chk("reset_busy", b0.o_busy, 0);
        chk("reset_overflow", b0.o_overflow, 0);
        rst_n = 1'b1;
        step(2);
        // 8N1 A5
        push(0, 'hA5, 1);
        wait_idle(0, 1500);
        chk("a5_line_bits", int'(cap[0][9:0]), 'h34A);
        chk("a5_frame_len", flen[0], 10);
        chk("a5_done_count", dcnt[0], 1);
        chk("a5_done_tick", done_at[0], 16);
        // even then odd parity on 07
        b0.i_parity_mode = PAR_EVEN;
        push(0, 'h07, 1);
        wait_idle(0, 1500);
        chk("even_line_bits", int'(cap[0][10:0]), 'h60E);
        chk("even_frame_len", flen[0], 11);
        b0.i_parity_mode = PAR_ODD;
        push(0, 'h07, 1);
        wait_idle(0, 1500);
        chk("odd_line_bits", int'(cap[0][10:0]), 'h40E);
        chk("parity_done_count", dcnt[0], 3);
        // two stop bits
        b0.i_parity_mode = PAR_NONE;
        b0.i_stop2 = 1'b1;
        push(0, 'h00, 1);
        wait_idle(0, 1500);
        chk("stop2_line_bits", int'(cap[0][9:0]), 'h200);
        chk("stop2_done_tick", done_at[0], 32);
        chk("stop2_done_count", dcnt[0], 4);
        // fill FIFO behind a running frame; fifth queued push overflows
        b0.i_stop2 = 1'b0;
        push(0, 'h11, 1);
        step(3);
        push(0, 'h22, 1);
        push(0, 'h33, 1);
        push(0, 'h44, 1);
        push(0, 'h55, 1);
        push(0, 'h66, 0);
        chk("busy_while_queued", b0.o_busy, 1);
        wait_idle(0, 5000);
        chk("burst_last_bits", int'(cap[0][9:0]), 'h2AA);
        chk("burst_done_count", dcnt[0], 9);
        // reset in the middle of data bit 3 with a word still queued
        push(0, 'hC3, 1);
        step(3);
        push(0, 'h3C, 1);
        wait_bit(0, 4, 5, 1500);
        d = dcnt[0];
        rst_n = 1'b0;
        #1;
        chk("abort_tx_high", b0.o_tx, 1);
        chk("abort_busy", b0.o_busy, 0);
        chk("abort_done", b0.o_done_tx, 0);
        step(3);
        rst_n = 1'b1;
        step(200);
        chk("abort_no_done", dcnt[0], d);
        chk("abort_tx_idle", b0.o_tx, 1);
        chk("abort_busy_after", b0.o_busy, 0);
        // 7-bit, 8 ticks/bit; config change mid-frame must not alter it
        push(1, 'h55, 1);
        wait_bit(1, 3, 2, 500);
        b1.i_parity_mode = PAR_EVEN;
        b1.i_stop2 = 1'b1;
        wait_idle(1, 1000);
        chk("n7_line_bits", int'(cap[1][8:0]), 'h1AA);
        chk("n7_frame_len", flen[1], 9);
        chk("n7_done_tick", done_at[1], 8);
        chk("n7_done_count", dcnt[1], 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
